// File: rtl/pixel_fb_writer.sv
// Point-plotting framebuffer writer: buffers (x, y) points, clips them, and emits linear RAM writes.
// Optional macro FB_DEDUP_EN drops a point equal to the previously written point of the same line.
module pixel_fb_writer #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int ADDR_W     = 19,
   parameter int COLOR_W    = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_x,
   input  logic [31:0]        in_y,
   input  logic [COLOR_W-1:0] in_color,
   input  logic               in_last,
   input  logic               clear_req,
   input  logic               fb_stall,
   output logic               fb_we,
   output logic [ADDR_W-1:0]  fb_addr,
   output logic [COLOR_W-1:0] fb_data,
   output logic               busy,
   output logic               done,
   output logic [15:0]        clip_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 32 + 32 + COLOR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

   typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;
   state_t state_reg, state_next;

   // input FIFO
   logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr_reg, rd_ptr_reg;
   logic               fifo_empty, fifo_full, push, pop;
   logic [31:0]        head_x, head_y;
   logic [COLOR_W-1:0] head_color;
   logic               head_last;

   // stage 1 (clip / dedup decision) and stage 2 (write register)
   logic                s1_valid_reg, s1_last_reg;
   logic signed [31:0]  s1_x_reg, s1_y_reg;
   logic [COLOR_W-1:0]  s1_color_reg;
   logic                s1_load, s1_in_bounds, s1_write, s1_clip, s1_dup;
   logic [ADDR_W-1:0]   s1_addr;

   logic                s2_valid_reg, s2_last_reg, fb_we_reg;
   logic [ADDR_W-1:0]   fb_addr_reg;
   logic [COLOR_W-1:0]  fb_data_reg;
   logic                s2_can;
   logic                s2_valid_next, s2_last_next, fb_we_next;
   logic [ADDR_W-1:0]   fb_addr_next;
   logic [COLOR_W-1:0]  fb_data_next;

   logic [15:0]         clip_count_reg;
   logic [ADDR_W-1:0]   clr_cnt_reg;
   logic                clr_sent_reg, clr_start;

   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                       (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
   assign in_ready   = rst_n && !fifo_full && (state_reg != CLEAR);
   assign push       = in_valid && in_ready;

   assign {head_x, head_y, head_color, head_last} = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

   // the write register only blocks when it holds a real write that the RAM refuses
   assign s2_can  = !(s2_valid_reg && fb_we_reg && fb_stall);
   assign s1_load = !s1_valid_reg || s2_can;
   assign pop     = !fifo_empty && s1_load && (state_reg != CLEAR);

   assign s1_in_bounds = (s1_x_reg >= 0) && (s1_x_reg < H_RES) &&
                         (s1_y_reg >= 0) && (s1_y_reg < V_RES);
   assign s1_addr      = ADDR_W'(s1_y_reg * H_RES + s1_x_reg);
   assign s1_write     = s1_valid_reg && s1_in_bounds && !s1_dup;
   assign s1_clip      = s1_valid_reg && !s1_in_bounds;

`ifdef FB_DEDUP_EN
   logic        dup_valid_reg;
   logic [31:0] dup_x_reg, dup_y_reg;

   assign s1_dup = dup_valid_reg && (s1_x_reg == dup_x_reg) && (s1_y_reg == dup_y_reg);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dup_valid_reg <= 1'b0;
         dup_x_reg     <= '0;
         dup_y_reg     <= '0;
      end else if (s1_valid_reg && s2_can) begin
         if (s1_last_reg) begin
            dup_valid_reg <= 1'b0;
         end else if (s1_write) begin
            dup_valid_reg <= 1'b1;
            dup_x_reg     <= s1_x_reg;
            dup_y_reg     <= s1_y_reg;
         end
      end
   end
`else
   assign s1_dup = 1'b0;
`endif

   // a dropped point carrying in_last still passes stage 2 as a no-write token so done stays ordered
   always_comb begin
      s2_valid_next = 1'b0;
      s2_last_next  = 1'b0;
      fb_we_next    = 1'b0;
      fb_addr_next  = fb_addr_reg;
      fb_data_next  = fb_data_reg;
      if (state_reg == CLEAR) begin
         s2_valid_next = !clr_sent_reg;
         fb_we_next    = !clr_sent_reg;
         s2_last_next  = (clr_cnt_reg == LAST_ADDR);
         fb_addr_next  = clr_cnt_reg;
         fb_data_next  = '0;
      end else begin
         s2_valid_next = s1_valid_reg && (s1_write || s1_last_reg);
         s2_last_next  = s1_last_reg;
         fb_we_next    = s1_write;
         if (s1_write) begin
            fb_addr_next = s1_addr;
            fb_data_next = s1_color_reg;
         end
      end
   end

   assign done = s2_valid_reg && s2_last_reg && s2_can;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (push)
               state_next = RUN;
            else if (clear_req && fifo_empty && !s1_valid_reg && !s2_valid_reg)
               state_next = CLEAR;
         end
         RUN: begin
            if (done && !push && fifo_empty && !s1_valid_reg)
               state_next = IDLE;
         end
         CLEAR: begin
            if (done)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign clr_start = (state_reg == IDLE) && (state_next == CLEAR);

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {in_x, in_y, in_color, in_last};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         s1_valid_reg   <= 1'b0;
         s1_last_reg    <= 1'b0;
         s1_x_reg       <= '0;
         s1_y_reg       <= '0;
         s1_color_reg   <= '0;
         s2_valid_reg   <= 1'b0;
         s2_last_reg    <= 1'b0;
         fb_we_reg      <= 1'b0;
         fb_addr_reg    <= '0;
         fb_data_reg    <= '0;
         clip_count_reg <= '0;
         clr_cnt_reg    <= '0;
         clr_sent_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + (PTR_W+1)'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + (PTR_W+1)'(1);
         if (s1_load) begin
            s1_valid_reg <= pop;
            if (pop) begin
               s1_x_reg     <= $signed(head_x);
               s1_y_reg     <= $signed(head_y);
               s1_color_reg <= head_color;
               s1_last_reg  <= head_last;
            end
         end
         if (s2_can) begin
            s2_valid_reg <= s2_valid_next;
            s2_last_reg  <= s2_last_next;
            fb_we_reg    <= fb_we_next;
            fb_addr_reg  <= fb_addr_next;
            fb_data_reg  <= fb_data_next;
         end
         if (s1_clip && s2_can && (clip_count_reg != 16'hFFFF))
            clip_count_reg <= clip_count_reg + 16'd1;
         if (clr_start) begin
            clr_cnt_reg  <= '0;
            clr_sent_reg <= 1'b0;
         end else if ((state_reg == CLEAR) && s2_can && !clr_sent_reg) begin
            clr_cnt_reg <= clr_cnt_reg + ADDR_W'(1);
            if (clr_cnt_reg == LAST_ADDR)
               clr_sent_reg <= 1'b1;
         end
      end
   end

   assign fb_we      = fb_we_reg;
   assign fb_addr    = fb_addr_reg;
   assign fb_data    = fb_data_reg;
   assign clip_count = clip_count_reg;
   assign busy       = (state_reg != IDLE) || !fifo_empty || s1_valid_reg || s2_valid_reg;

endmodule
